// File: rtl/conv_out_stream.sv
// Output-side collector for conv_top: buffers unthrottled data_out beats in a FWFT FIFO
// and re-emits them on a valid/ready stream with frame accounting and error flags.
module conv_out_stream #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   cfg_out_width,
    input  logic [15:0]                   cfg_out_height,
    input  logic                          go,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          data_in_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          extra_beat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW-1:0]    PTR_ZERO = AW'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;

    logic [DATA_W-1:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW:0]           level_r;

    logic [CNT_W-1:0]      total_r;
    logic [CNT_W-1:0]      in_cnt_r;
    logic [CNT_W-1:0]      out_cnt_r;
    logic                  overflow_r;
    logic                  extra_r;

    logic [31:0]           prod_s;
    logic [CNT_W-1:0]      total_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  last_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  drop_full_s;
    logic                  extra_s;
    logic                  start_s;
    logic                  busy_s;
    logic                  done_s;

    assign prod_s  = 32'(cfg_out_width) * 32'(cfg_out_height);
    assign total_s = CNT_W'(prod_s);
    assign start_s = (state_r == S_IDLE) && go;

    assign full_s  = (level_r == LVL_FULL);
    assign empty_s = (level_r == LVL_ZERO);
    assign pop_s   = !empty_s && m_ready;
    assign last_s  = !empty_s && (out_cnt_r == (total_r - CNT_ONE));

    // A slot in the frame is consumed even when the beat is lost, keeping the count aligned.
    assign accept_s    = (state_r == S_RUN) && data_in_valid && (in_cnt_r < total_r);
    assign push_s      = accept_s && (!full_s || pop_s);
    assign drop_full_s = accept_s && full_s && !pop_s;
    assign extra_s     = data_in_valid &&
                         (((state_r == S_RUN) && (in_cnt_r >= total_r)) || (state_r == S_DRAIN));

    // FIFO storage write port; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame total, beat counters and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            total_r    <= CNT_ZERO;
            in_cnt_r   <= CNT_ZERO;
            out_cnt_r  <= CNT_ZERO;
            overflow_r <= 1'b0;
            extra_r    <= 1'b0;
        end else if (start_s) begin
            total_r    <= total_s;
            in_cnt_r   <= CNT_ZERO;
            out_cnt_r  <= CNT_ZERO;
            overflow_r <= 1'b0;
            extra_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                in_cnt_r <= in_cnt_r + CNT_ONE;
            end
            if (pop_s) begin
                out_cnt_r <= out_cnt_r + CNT_ONE;
            end
            if (drop_full_s) begin
                overflow_r <= 1'b1;
            end
            if (extra_s) begin
                extra_r <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    state_s = (total_s == CNT_ZERO) ? S_DONE : S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && ((in_cnt_r + CNT_ONE) == total_r)) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                // With dropped beats m_last can never fire, so an emptied FIFO ends the frame.
                if (pop_s && last_s) begin
                    state_s = S_DONE;
                end else if (overflow_r && empty_s && (in_cnt_r == total_r)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Status decode from the state register
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            S_RUN:   busy_s = 1'b1;
            S_DRAIN: busy_s = 1'b1;
            S_DONE:  done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    assign m_valid    = !empty_s;
    assign m_data     = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
    assign m_last     = last_s;
    assign busy       = busy_s;
    assign done       = done_s;
    assign overflow   = overflow_r;
    assign extra_beat = extra_r;
    assign fifo_level = level_r;

endmodule
